// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_pkg
// Description : Shared widths, default device address, receiver state
//               encoding and a saturating-counter helper for i2c_slave_rx.
// Revision    : 1.0  initial release
// ============================================================================
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;
    localparam int I2C_WORD_W = 16;

    localparam logic [I2C_ADDR_W-1:0] I2C_DEFAULT_DEV_ADDR = 7'h1A;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_DATA_HI   = 3'd3,
        ST_ACK_HI    = 3'd4,
        ST_DATA_LO   = 3'd5,
        ST_ACK_LO    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } i2c_rx_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage : i2c_pkg
`default_nettype wire

// File: rtl/i2c_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : i2c_sync_edge
// Description : Multi-flop synchronizer for one I2C line, optional 3-sample
//               majority filter (I2C_GLITCH_FILT_EN, +2 clk latency, rejects
//               pulses of 1 clk or less), then level / rise / fall outputs.
// Revision    : 1.0  initial release
// ============================================================================
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter bit RESET_VAL   = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    // Fewer than two flops is not a synchronizer; clamp silently.
    localparam int c_STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [c_STAGES-1:0] sync_q;
    logic                w_sync;
    logic                w_level;
    logic                prev_q;

    // Synchronizer chain; resets to the idle (pulled-up) bus level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {c_STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[c_STAGES-2:0], in_i};
        end
    end

    assign w_sync = sync_q[c_STAGES-1];

`ifdef I2C_GLITCH_FILT_EN
    logic [1:0] hist_q;
    logic       filt_q;

    // Majority of the current and two previous samples, registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= {2{RESET_VAL}};
            filt_q <= RESET_VAL;
        end else begin
            hist_q <= {hist_q[0], w_sync};
            filt_q <= (w_sync & hist_q[0]) | (w_sync & hist_q[1]) | (hist_q[0] & hist_q[1]);
        end
    end

    assign w_level = filt_q;
`else
    assign w_level = w_sync;
`endif

    // Previous level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= RESET_VAL;
        end else begin
            prev_q <= w_level;
        end
    end

    assign level_o = w_level;
    assign rise_o  = w_level & ~prev_q;
    assign fall_o  = ~w_level & prev_q;

endmodule : i2c_sync_edge
`default_nettype wire

// File: rtl/i2c_slave_rx.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave_rx
// Description : I2C target receiver for a 3-byte write (address + R/W, data
//               high byte, data low byte). Oversamples SCL/SDA on clk, ACKs
//               matching writes and emits each 16-bit word as a one-cycle
//               strobe. SDA is only ever pulled low or released.
//               Optional build macro: I2C_GLITCH_FILT_EN (input majority
//               filter inside i2c_sync_edge).
// Revision    : 1.0  initial release
// ============================================================================
module i2c_slave_rx
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] DEV_ADDR    = I2C_DEFAULT_DEV_ADDR,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    inout  wire                   sdin,
    output logic                  wr_valid,
    output logic [I2C_WORD_W-1:0] wr_data,
    output logic                  busy,
    output logic [7:0]            nack_cnt
);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic w_scl_level, w_scl_rise, w_scl_fall;
    logic w_sda_level, w_sda_rise, w_sda_fall;

    i2c_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_sync_scl (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_i    (sclk),
        .level_o (w_scl_level),
        .rise_o  (w_scl_rise),
        .fall_o  (w_scl_fall)
    );

    i2c_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_sync_sda (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_i    (sdin),
        .level_o (w_sda_level),
        .rise_o  (w_sda_rise),
        .fall_o  (w_sda_fall)
    );

    // Bus conditions: SDA moving while SCL is high.
    logic w_start, w_stop;
    assign w_start = w_sda_fall & w_scl_level;
    assign w_stop  = w_sda_rise & w_scl_level;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    i2c_rx_state_e         state_q,     state_d;
    logic [2:0]            bit_cnt_q,   bit_cnt_d;
    logic [I2C_BYTE_W-1:0] shift_q,     shift_d;
    logic                  byte_done_q, byte_done_d;  // 8 bits sampled, awaiting the closing SCL fall
    logic                  ack_slot_q,  ack_slot_d;   // inside a released (NACK) 9th clock
    logic [I2C_BYTE_W-1:0] hi_q,        hi_d;
    logic                  sda_oe_q,    sda_oe_d;
    logic                  busy_q,      busy_d;
    logic                  wr_valid_q,  wr_valid_d;
    logic [I2C_WORD_W-1:0] wr_data_q,   wr_data_d;
    logic [7:0]            nack_cnt_q,  nack_cnt_d;

    logic w_addr_match;
    assign w_addr_match = (shift_q[I2C_BYTE_W-1:1] == DEV_ADDR);

    // State register; reset releases SDA immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd7;
            shift_q     <= '0;
            byte_done_q <= 1'b0;
            ack_slot_q  <= 1'b0;
            hi_q        <= '0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_data_q   <= '0;
            nack_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            byte_done_q <= byte_done_d;
            ack_slot_q  <= ack_slot_d;
            hi_q        <= hi_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_valid_q  <= wr_valid_d;
            wr_data_q   <= wr_data_d;
            nack_cnt_q  <= nack_cnt_d;
        end
    end

    // Next-state logic: START/STOP first, then per-state bit handling.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        byte_done_d = byte_done_q;
        ack_slot_d  = ack_slot_q;
        hi_d        = hi_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_valid_d  = 1'b0;
        wr_data_d   = wr_data_q;
        nack_cnt_d  = nack_cnt_q;

        if (w_start) begin
            // START or repeated START: drop any partial frame.
            state_d     = ST_ADDR;
            bit_cnt_d   = 3'd7;
            byte_done_d = 1'b0;
            ack_slot_d  = 1'b0;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
        end else if (w_stop) begin
            state_d     = ST_IDLE;
            bit_cnt_d   = 3'd7;
            byte_done_d = 1'b0;
            ack_slot_d  = 1'b0;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Nothing but a START matters here.
                end

                ST_ADDR, ST_DATA_HI, ST_DATA_LO, ST_WAIT_STOP: begin
                    if (ack_slot_q) begin
                        // Released 9th clock; the next byte starts after its fall.
                        if (w_scl_fall) begin
                            ack_slot_d = 1'b0;
                            bit_cnt_d  = 3'd7;
                        end
                    end else if (w_scl_rise && !byte_done_q) begin
                        shift_d = {shift_q[I2C_BYTE_W-2:0], w_sda_level};
                        if (bit_cnt_q == 3'd0) begin
                            byte_done_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                        end
                    end else if (w_scl_fall && byte_done_q) begin
                        // Fall that ends bit 0: decide ACK or NACK for the 9th clock.
                        byte_done_d = 1'b0;
                        bit_cnt_d   = 3'd7;
                        case (state_q)
                            ST_ADDR: begin
                                if (w_addr_match && !shift_q[0]) begin
                                    state_d  = ST_ADDR_ACK;
                                    sda_oe_d = 1'b1;
                                    busy_d   = 1'b1;
                                end else begin
                                    // Reads are unsupported and counted; foreign addresses are not.
                                    if (w_addr_match) begin
                                        nack_cnt_d = sat_inc8(nack_cnt_q);
                                    end
                                    state_d    = ST_WAIT_STOP;
                                    ack_slot_d = 1'b1;
                                end
                            end
                            ST_DATA_HI: begin
                                hi_d     = shift_q;
                                sda_oe_d = 1'b1;
                                state_d  = ST_ACK_HI;
                            end
                            ST_DATA_LO: begin
                                sda_oe_d = 1'b1;
                                state_d  = ST_ACK_LO;
                            end
                            default: begin
                                // Extra byte after the word: NACK it.
                                nack_cnt_d = sat_inc8(nack_cnt_q);
                                ack_slot_d = 1'b1;
                            end
                        endcase
                    end
                end

                ST_ADDR_ACK, ST_ACK_HI, ST_ACK_LO: begin
                    // Hold SDA low through the 9th clock, release on its fall.
                    if (w_scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 3'd7;
                        case (state_q)
                            ST_ADDR_ACK: state_d = ST_DATA_HI;
                            ST_ACK_HI:   state_d = ST_DATA_LO;
                            default: begin
                                wr_data_d  = {hi_q, shift_q};
                                wr_valid_d = 1'b1;
                                state_d    = ST_WAIT_STOP;
                            end
                        endcase
                    end
                end

                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // Open-drain output: pull low or float, never drive high.
    assign sdin     = sda_oe_q ? 1'b0 : 1'bz;
    assign wr_valid = wr_valid_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign nack_cnt = nack_cnt_q;

endmodule : i2c_slave_rx
`default_nettype wire

// File: tb/tb_i2c_slave_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_slave_rx
// Description : Self-checking bench for i2c_slave_rx. A bit-banged master
//               drives directed frames; expected words go into a queue that
//               a separate monitor drains on every wr_valid.
// Revision    : 1.0  initial release
// ============================================================================
module tb_i2c_slave_rx;

    localparam int c_Q = 10;  // quarter SCL period in clk cycles

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        scl       = 1'b1;
    logic        m_sda_low = 1'b0;
    wire         sdin_bus;
    logic        wr_valid;
    logic [15:0] wr_data;
    logic        busy;
    logic [7:0]  nack_cnt;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    assign sdin_bus = m_sda_low ? 1'b0 : 1'bz;
    pullup (sdin_bus);

    i2c_slave_rx #(
        .DEV_ADDR    (7'h1A),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sclk     (scl),
        .sdin     (sdin_bus),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .busy     (busy),
        .nack_cnt (nack_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic m_start;
        m_sda_low = 1'b1; wait_clk(c_Q);
        scl = 1'b0;       wait_clk(c_Q);
    endtask

    task automatic m_bit(input logic b);
        m_sda_low = ~b; wait_clk(c_Q);
        scl = 1'b1;     wait_clk(2 * c_Q);
        scl = 1'b0;     wait_clk(c_Q);
    endtask

    // Ninth clock: master releases SDA and samples the bus; 0 means ACK.
    task automatic m_ack(output logic a);
        m_sda_low = 1'b0; wait_clk(c_Q);
        scl = 1'b1;       wait_clk(c_Q);
        a = sdin_bus;     wait_clk(c_Q);
        scl = 1'b0;       wait_clk(c_Q);
    endtask

    task automatic m_byte(input logic [7:0] b, output logic a);
        for (int i = 7; i >= 0; i--) m_bit(b[i]);
        m_ack(a);
    endtask

    task automatic m_stop;
        m_sda_low = 1'b1; wait_clk(c_Q);
        scl = 1'b1;       wait_clk(c_Q);
        m_sda_low = 1'b0; wait_clk(c_Q);
    endtask

    task automatic m_rstart;
        m_sda_low = 1'b0; wait_clk(c_Q);
        scl = 1'b1;       wait_clk(c_Q);
        m_sda_low = 1'b1; wait_clk(c_Q);
        scl = 1'b0;       wait_clk(c_Q);
    endtask

    // Full 3-byte write to address byte 8'h34 with every ACK checked.
    task automatic do_write(input logic [15:0] w);
        logic a;
        exp_q.push_back(w);
        m_start;
        m_byte(8'h34, a);   chk("write addr ack", a, 0);
        m_byte(w[15:8], a); chk("write hi ack", a, 0);
        m_byte(w[7:0], a);  chk("write lo ack", a, 0);
        m_stop;
        wait_clk(c_Q);
    endtask

    // Monitor: every strobe must match the oldest expected word.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && wr_valid) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_wr_valid: got wr_data %h, no word expected", wr_data);
                end else begin
                    chk("scoreboard wr_data", wr_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic a;

        // Reset state
        wait_clk(5);
        chk("reset wr_valid", wr_valid, 0);
        chk("reset wr_data", wr_data, 16'h0000);
        chk("reset busy", busy, 0);
        chk("reset nack_cnt", nack_cnt, 0);
        chk("reset sda released", sdin_bus, 1);
        rst_n = 1'b1;
        wait_clk(5);

        // Matching write of 16'hA55A
        exp_q.push_back(16'hA55A);
        m_start;
        m_byte(8'h34, a); chk("t1 addr ack", a, 0);
        chk("t1 busy after match", busy, 1);
        m_byte(8'hA5, a); chk("t1 hi ack", a, 0);
        m_byte(8'h5A, a); chk("t1 lo ack", a, 0);
        wait_clk(2);
        chk("t1 wr_data", wr_data, 16'hA55A);
        m_stop;
        wait_clk(c_Q);
        chk("t1 busy after stop", busy, 0);

        // Foreign address: stays released, not counted
        m_start;
        m_byte(8'h36, a); chk("t2 mismatch released", a, 1);
        chk("t2 busy", busy, 0);
        m_stop;
        wait_clk(c_Q);
        chk("t2 nack_cnt", nack_cnt, 0);

        // Read to own address: NACK and count
        m_start;
        m_byte(8'h35, a); chk("t3 read nack", a, 1);
        chk("t3 nack_cnt", nack_cnt, 1);
        m_stop;
        wait_clk(c_Q);
        chk("t3 busy", busy, 0);

        // STOP after the first data byte, then a clean write
        m_start;
        m_byte(8'h34, a); chk("t4 addr ack", a, 0);
        m_byte(8'hFF, a); chk("t4 hi ack", a, 0);
        m_stop;
        wait_clk(c_Q);
        chk("t4 busy after abort", busy, 0);
        chk("t4 wr_data unchanged", wr_data, 16'hA55A);
        do_write(16'h0102);
        chk("t4 wr_data", wr_data, 16'h0102);

        // Repeated START in the middle of the low byte
        exp_q.push_back(16'h1234);
        m_start;
        m_byte(8'h34, a); chk("t5 addr ack", a, 0);
        m_byte(8'h99, a); chk("t5 hi ack", a, 0);
        m_bit(1'b1); m_bit(1'b0); m_bit(1'b1); m_bit(1'b0);
        m_rstart;
        chk("t5 busy after rstart", busy, 0);
        m_byte(8'h34, a); chk("t5 addr2 ack", a, 0);
        m_byte(8'h12, a); chk("t5 hi2 ack", a, 0);
        m_byte(8'h34, a); chk("t5 lo2 ack", a, 0);
        m_stop;
        wait_clk(c_Q);
        chk("t5 wr_data", wr_data, 16'h1234);
        chk("t5 nack_cnt", nack_cnt, 1);

        // Reset while the high-byte ACK is being driven
        m_start;
        m_byte(8'h34, a); chk("t6 addr ack", a, 0);
        for (int i = 7; i >= 0; i--) m_bit(i[0]);
        m_sda_low = 1'b0; wait_clk(c_Q);
        scl = 1'b1;       wait_clk(2);
        chk("t6 ack_hi driven", sdin_bus, 0);
        chk("t6 busy", busy, 1);
        rst_n = 1'b0;
        wait_clk(1);
        chk("t6 sda released in reset", sdin_bus, 1);
        chk("t6 busy in reset", busy, 0);
        chk("t6 wr_data in reset", wr_data, 16'h0000);
        chk("t6 nack_cnt in reset", nack_cnt, 0);
        chk("t6 wr_valid in reset", wr_valid, 0);
        rst_n = 1'b1;
        wait_clk(c_Q);
        scl = 1'b0;       wait_clk(c_Q);
        m_sda_low = 1'b1; wait_clk(c_Q);
        scl = 1'b1;       wait_clk(c_Q);
        m_sda_low = 1'b0; wait_clk(c_Q);

`ifdef I2C_GLITCH_FILT_EN
        // 1-clk SDA spike with SCL high must not look like a START
        m_sda_low = 1'b1; wait_clk(1);
        m_sda_low = 1'b0; wait_clk(c_Q);
        chk("t7 busy after glitch", busy, 0);
        scl = 1'b0; wait_clk(c_Q);
        m_byte(8'h34, a); chk("t7 no start from glitch", a, 1);
        m_stop;
        wait_clk(c_Q);
`endif

        // Normal operation after reset
        do_write(16'hBEEF);
        chk("t8 wr_data", wr_data, 16'hBEEF);
        chk("t8 nack_cnt", nack_cnt, 0);
        chk("t8 busy", busy, 0);

        wait_clk(20);
        chk("scoreboard drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_i2c_slave_rx
`default_nettype wire
